// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan reader.
//   - Segment patterns for digits 0-9 and blank, bit order {a,b,c,d,e,f,g}, a = bit 6.
//   - BCD codes reported for a blank digit and for an unrecognised pattern.
//   - Stability tracker state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_INVALID = 4'hE;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    HELD
  } trk_state_e;

endpackage

// File: rtl/seg_scan_reader_if.sv
// Frame delivery interface of the 7-segment scan reader.
//   frame_valid  frame available (master -> slave)
//   frame_ready  consumer accepts the frame (slave -> master)
//   bcd_out      digit i in bits [4i+3:4i] (master -> slave)
//   err_out      per-digit invalid-pattern flag (master -> slave)
//   overrun      sticky dropped-frame flag (master -> slave)
//   overrun_clr  synchronous clear of overrun (slave -> master)
interface seg_scan_reader_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();

  logic                      frame_valid;
  logic                      frame_ready;
  logic [4*NUM_DIGITS-1:0]   bcd_out;
  logic [NUM_DIGITS-1:0]     err_out;
  logic                      overrun;
  logic                      overrun_clr;

  modport master (
    output frame_valid,
    output bcd_out,
    output err_out,
    output overrun,
    input  frame_ready,
    input  overrun_clr
  );

  modport slave (
    input  frame_valid,
    input  bcd_out,
    input  err_out,
    input  overrun,
    output frame_ready,
    output overrun_clr
  );

endinterface

// File: rtl/seg_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder (inverse of the BCD-to-7-segment encoder).
//   seg  in   7-bit pattern {a,b,c,d,e,f,g}
//   bcd  out  decoded digit, BCD_BLANK for a dark digit, BCD_INVALID otherwise
//   err  out  1 when the pattern is neither a digit nor blank
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = BCD_INVALID;
    err = 1'b0;
    unique case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default: begin
        bcd = BCD_INVALID;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment display reader.
// Synchronizes the segment and digit-select lines, waits for each scanned pattern to be stable,
// decodes it back to BCD and assembles one value per digit position into a frame that is
// delivered over a valid/ready handshake.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   seg_in   in   segment lines {a,b,c,d,e,f,g}
//   dig_sel  in   one-hot digit enables
//   bus      frame output interface (frame_valid/ready, bcd_out, err_out, overrun, overrun_clr)
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel,
  seg_scan_reader_if.master     bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam int unsigned SmpW = NUM_DIGITS + 7;

  // Input synchronizers
  logic [SYNC_STAGES-1:0][6:0]            seg_sync_q;
  logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] dig_sync_q;
  logic [6:0]                             seg_s;
  logic [NUM_DIGITS-1:0]                  dig_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_sync_q <= '0;
      dig_sync_q <= '0;
    end else begin
      seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg_in};
      dig_sync_q <= {dig_sync_q[SYNC_STAGES-2:0], dig_sel};
    end
  end

  assign seg_s = seg_sync_q[SYNC_STAGES-1];
  assign dig_s = dig_sync_q[SYNC_STAGES-1];

  // Stability tracker
  trk_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SmpW-1:0] prev_q;
  logic            same;
  logic            dig_onehot;
  logic            capture;

  assign same       = ({dig_s, seg_s} == prev_q);
  assign dig_onehot = $onehot(dig_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= {dig_s, seg_s};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!dig_onehot) begin
      state_d = WAIT;
      cnt_d   = '0;
    end else if (state_q == HELD && same) begin
      state_d = HELD;
    end else begin
      // The count includes the current sample, so a fresh pattern starts at 1.
      if (state_q == SETTLE && same) begin
        cnt_d = (cnt_q >= CntW'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = CntW'(1);
      end
      if (cnt_d >= CntW'(STABLE_CYC)) begin
        capture = 1'b1;
        state_d = HELD;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  // Decode
  logic [3:0] dec_bcd;
  logic       dec_err;

  seg_to_bcd u_dec (
    .seg (seg_s),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Frame assembly and delivery
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] bcd_out_q, bcd_out_d;
  logic [NUM_DIGITS-1:0]   err_out_q, err_out_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    complete;
  logic                    drop;

  always_comb begin
    dig_d         = dig_q;
    err_d         = err_q;
    seen_d        = seen_q;
    bcd_out_d     = bcd_out_q;
    err_out_d     = err_out_q;
    frame_valid_d = frame_valid_q && !bus.frame_ready;
    complete      = 1'b0;
    drop          = 1'b0;

    if (capture) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (dig_s[i]) begin
          dig_d[4*i +: 4] = dec_bcd;
          err_d[i]        = dec_err;
        end
      end
      seen_d = seen_q | dig_s;
      if (&seen_d) begin
        complete = 1'b1;
        seen_d   = '0;
      end
    end

    // The completing digit comes from dig_d so it reaches the output on the capture edge.
    if (complete) begin
      if (!frame_valid_q || bus.frame_ready) begin
        bcd_out_d     = dig_d;
        err_out_d     = err_d;
        frame_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q         <= '0;
      err_q         <= '0;
      seen_q        <= '0;
      bcd_out_q     <= '0;
      err_out_q     <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      dig_q         <= dig_d;
      err_q         <= err_d;
      seen_q        <= seen_d;
      bcd_out_q     <= bcd_out_d;
      err_out_q     <= err_out_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.bcd_out     = bcd_out_q;
  assign bus.err_out     = err_out_q;
  assign bus.overrun     = overrun_q;

endmodule
